// File: rtl/fp27_pkg.sv
// fp27_pkg: FP27 field layout, field extractors and lane classification
package fp27_pkg;
  localparam int FP27_W    = 27;
  localparam int EXP_W     = 8;
  localparam int MANT_W    = 18;
  localparam int FP27_BIAS = 127;

  typedef enum logic [1:0] {ZERO, SAT, NORM} lane_cls_e;

  function automatic logic fp_sign(input logic [FP27_W-1:0] v);
    return v[FP27_W-1];
  endfunction

  function automatic logic [EXP_W-1:0] fp_exp(input logic [FP27_W-1:0] v);
    return v[FP27_W-2 -: EXP_W];
  endfunction

  function automatic logic [MANT_W-1:0] fp_mant(input logic [FP27_W-1:0] v);
    return v[MANT_W-1:0];
  endfunction
endpackage

// File: rtl/fp27_to_u8.sv
// fp27_to_u8: one lane of FP27 to 8-bit truncating conversion, classify registered then shift
module fp27_to_u8
  import fp27_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [FP27_W-1:0] fp,
  output logic [7:0]        u8
);
  logic [EXP_W-1:0]  e;
  lane_cls_e         cls_d, cls_q;
  logic [4:0]        sh_d, sh_q;
  logic [MANT_W-1:0] mant_q;

  // exponents at or below bias-9 shift the hidden one out entirely, so they fold into ZERO
  always_comb begin
    e     = fp_exp(fp);
    cls_d = (fp_sign(fp) || e <= 8'(FP27_BIAS - 9)) ? ZERO : (e >= 8'(FP27_BIAS)) ? SAT : NORM;
    sh_d  = 5'(8'(FP27_BIAS + 10) - e);
  end

  // stage-1 register: class, shift amount and mantissa
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q  <= ZERO;
      sh_q   <= '0;
      mant_q <= '0;
    end else if (en) begin
      cls_q  <= cls_d;
      sh_q   <= sh_d;
      mant_q <= fp_mant(fp);
    end
  end

  // shift half: exp 126 with a full mantissa lands exactly on 255, so no clamp is needed
  always_comb u8 = (cls_q == ZERO) ? 8'd0 : (cls_q == SAT) ? 8'hFF : 8'({1'b1, mant_q} >> sh_q);
endmodule

// File: rtl/vec_fp_to_rgb.sv
// vec_fp_to_rgb: FP27 rgb vector to 8-bit channels tagged with raster position, two-stage pipe
module vec_fp_to_rgb
  import fp27_pkg::*;
#(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [FP27_W-1:0] i_r,
  input  logic [FP27_W-1:0] i_g,
  input  logic [FP27_W-1:0] i_b,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [7:0]        o_r8,
  output logic [7:0]        o_g8,
  output logic [7:0]        o_b8,
  output logic [9:0]        o_x,
  output logic [8:0]        o_y,
  output logic              o_last
);
  logic       adv, take, v1, last1, x_end, y_end;
  logic [9:0] x_cnt, x1;
  logic [8:0] y_cnt, y1;
  logic [7:0] r8, g8, b8;

  assign adv     = !o_valid || i_ready;
  assign o_ready = adv || !v1;
  assign take    = i_valid && o_ready;
  assign x_end   = x_cnt == 10'(H_RES - 1);
  assign y_end   = y_cnt == 9'(V_RES - 1);

  fp27_to_u8 u_r (.clk(i_clk), .rst_n(i_rst_n), .en(o_ready), .fp(i_r), .u8(r8));
  fp27_to_u8 u_g (.clk(i_clk), .rst_n(i_rst_n), .en(o_ready), .fp(i_g), .u8(g8));
  fp27_to_u8 u_b (.clk(i_clk), .rst_n(i_rst_n), .en(o_ready), .fp(i_b), .u8(b8));

  // raster counter advances once per accepted input
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (take) begin
      x_cnt <= x_end ? 10'd0 : x_cnt + 10'd1;
      y_cnt <= x_end ? (y_end ? 9'd0 : y_cnt + 9'd1) : y_cnt;
    end
  end

  // stage-1 valid and sideband; loads whenever the block is ready, even into a stalled stage 2
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v1    <= 1'b0;
      x1    <= '0;
      y1    <= '0;
      last1 <= 1'b0;
    end else if (o_ready) begin
      v1    <= i_valid;
      x1    <= x_cnt;
      y1    <= y_cnt;
      last1 <= x_end && y_end;
    end
  end

  // stage-2 output register, held while downstream stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_r8    <= '0;
      o_g8    <= '0;
      o_b8    <= '0;
      o_x     <= '0;
      o_y     <= '0;
      o_last  <= 1'b0;
    end else if (adv) begin
      o_valid <= v1;
      o_r8    <= r8;
      o_g8    <= g8;
      o_b8    <= b8;
      o_x     <= x1;
      o_y     <= y1;
      o_last  <= last1;
    end
  end
endmodule

// File: tb/tb_vec_fp_to_rgb.sv
// tb_vec_fp_to_rgb: directed and random checks of the FP27 to rgb8 back end on a 4x2 raster
module tb_vec_fp_to_rgb;
  localparam int H = 4;
  localparam int V = 2;

  typedef struct packed {
    logic [7:0] r, g, b;
    logic [9:0] x;
    logic [8:0] y;
    logic       last;
  } pix_t;

  logic        i_clk = 1'b0, i_rst_n = 1'b1, i_valid = 1'b0, i_ready = 1'b1;
  logic        o_ready, o_valid, o_last;
  logic [26:0] i_r = '0, i_g = '0, i_b = '0;
  logic [7:0]  o_r8, o_g8, o_b8;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  int          n_cmp = 0, n_bad = 0;
  bit          log_on = 0, sb_on = 0;
  pix_t        log_q[$], sb_q[$];
  int          mx = 0, my = 0;

  always #5 i_clk = ~i_clk;

  vec_fp_to_rgb #(.H_RES(H), .V_RES(V)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_r(i_r), .i_g(i_g), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_r8(o_r8), .o_g8(o_g8), .o_b8(o_b8), .o_x(o_x), .o_y(o_y), .o_last(o_last)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pix_t mk(input logic [7:0] r, g, b, input logic [9:0] x, input logic [8:0] y, input logic l);
    return {r, g, b, x, y, l};
  endfunction

  function automatic logic [7:0] ref_u8(input logic [26:0] f);
    real v;
    if (f[26] || f[25:18] == 8'd0) return 8'd0;
    v = (262144.0 + real'(f[17:0])) / 262144.0 * (2.0 ** (real'(f[25:18]) - 119.0));
    return (v >= 255.0) ? 8'd255 : 8'($rtoi(v));
  endfunction

  function automatic logic [26:0] rnd();
    int p = $urandom_range(0, 9);
    logic [7:0] e = (p == 0) ? 8'd0 : (p == 1) ? 8'($urandom_range(127, 255)) : 8'($urandom_range(112, 128));
    return {($urandom_range(0, 7) == 0), e, 18'($urandom)};
  endfunction

  function automatic pix_t cur();
    return {o_r8, o_g8, o_b8, o_x, o_y, o_last};
  endfunction

  // output logger and reference scoreboard, sampled mid-cycle
  always @(negedge i_clk) begin
    pix_t p;
    if (sb_on && i_valid && o_ready) begin
      p = mk(ref_u8(i_r), ref_u8(i_g), ref_u8(i_b), 10'(mx), 9'(my), mx == H - 1 && my == V - 1);
      sb_q.push_back(p);
      if (mx == H - 1) begin
        mx = 0;
        my = (my == V - 1) ? 0 : my + 1;
      end else mx++;
    end
    if (sb_on && o_valid && i_ready) begin
      chk("sb_entry", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) chk("sb_pixel", 64'(cur()), 64'(sb_q.pop_front()));
    end
    if (log_on && o_valid && i_ready) log_q.push_back(cur());
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic put(input logic [26:0] r, g, b);
    i_valid = 1'b1;
    i_r = r;
    i_g = g;
    i_b = b;
  endtask

  task automatic rst_pulse();
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
    step();
  endtask

  task automatic one(input string tag, input logic [26:0] r, g, b, input logic [7:0] er, eg, eb,
                     input logic [9:0] ex, input logic [8:0] ey, input logic el);
    put(r, g, b);
    step();
    i_valid = 1'b0;
    step();
    chk({tag, "_valid"}, 64'(o_valid), 64'd1);
    chk({tag, "_pix"}, 64'(cur()), 64'(mk(er, eg, eb, ex, ey, el)));
    step();
    chk({tag, "_drain"}, 64'(o_valid), 64'd0);
  endtask

  initial begin
    bit took = 0;
    int xs[9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
    int ys[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    pix_t bp_exp[4];
    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_pix", 64'(cur()), 64'd0);
    step();
    step();
    i_rst_n = 1'b1;
    step();
    chk("rst_ready", 64'(o_ready), 64'd1);

    // 1.0, 0.5, 0.0 / -0.5, 2.0, just under 1/128 / exp126 full mant, exp118, exp119 zero mant
    one("known", 27'h1FC0000, 27'h1F80000, 27'h0000000, 8'd255, 8'd128, 8'd0, 10'd0, 9'd0, 1'b0);
    one("bound", 27'h5F80000, 27'h2000000, 27'h1DFFFFF, 8'd0, 8'd255, 8'd1, 10'd1, 9'd0, 1'b0);
    one("edge", 27'h1FBFFFF, 27'h1DBFFFF, 27'h1DC0000, 8'd255, 8'd0, 8'd1, 10'd2, 9'd0, 1'b0);

    // back-pressure with a bubble that fills behind a stalled output
    log_q.delete();
    log_on = 1;
    put(27'h1FC0000, 27'h0, 27'h0);
    step();
    i_valid = 1'b0;
    step();
    i_ready = 1'b0;
    put(27'h1F80000, 27'h0, 27'h0);
    #1;
    chk("bp_fill_ready", 64'(o_ready), 64'd1);
    step();
    chk("bp_full_ready", 64'(o_ready), 64'd0);
    chk("bp_hold1", 64'(cur()), 64'(mk(8'd255, 8'd0, 8'd0, 10'd3, 9'd0, 1'b0)));
    put(27'h1FA0000, 27'h0, 27'h0);
    step();
    chk("bp_full_ready2", 64'(o_ready), 64'd0);
    chk("bp_hold2", 64'(cur()), 64'(mk(8'd255, 8'd0, 8'd0, 10'd3, 9'd0, 1'b0)));
    chk("bp_hold_valid", 64'(o_valid), 64'd1);
    i_ready = 1'b1;
    step();
    put(27'h1DFFFFF, 27'h0, 27'h0);
    step();
    i_valid = 1'b0;
    step();
    step();
    log_on = 0;
    bp_exp = '{mk(8'd255, 8'd0, 8'd0, 10'd3, 9'd0, 1'b0), mk(8'd128, 8'd0, 8'd0, 10'd0, 9'd1, 1'b0),
               mk(8'd192, 8'd0, 8'd0, 10'd1, 9'd1, 1'b0), mk(8'd1, 8'd0, 8'd0, 10'd2, 9'd1, 1'b0)};
    chk("bp_count", 64'(log_q.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp_pix%0d", k), (k < log_q.size()) ? 64'(log_q[k]) : 64'hDEAD, 64'(bp_exp[k]));

    // reset with two pixels in flight
    put(27'h1FC0000, 27'h0, 27'h0);
    step();
    put(27'h1F80000, 27'h0, 27'h0);
    step();
    i_valid = 1'b0;
    #3 i_rst_n = 1'b0;
    #1;
    chk("mrst_valid", 64'(o_valid), 64'd0);
    chk("mrst_pix", 64'(cur()), 64'd0);
    step();
    i_rst_n = 1'b1;
    step();
    chk("mrst_ready", 64'(o_ready), 64'd1);
    one("mrst_first", 27'h1F80000, 27'h1FC0000, 27'h0, 8'd128, 8'd255, 8'd0, 10'd0, 9'd0, 1'b0);
    one("mrst_second", 27'h1FA0000, 27'h0, 27'h1FC0000, 8'd192, 8'd0, 8'd255, 10'd1, 9'd0, 1'b0);

    // raster wrap over nine back-to-back pixels
    rst_pulse();
    log_q.delete();
    log_on = 1;
    for (int k = 0; k < 9; k++) begin
      put(27'h1F80000 | 27'(k << 11), 27'h0, 27'h0);
      step();
    end
    i_valid = 1'b0;
    repeat (3) step();
    log_on = 0;
    chk("ras_count", 64'(log_q.size()), 64'd9);
    for (int k = 0; k < 9; k++)
      chk($sformatf("ras_pix%0d", k), (k < log_q.size()) ? 64'(log_q[k]) : 64'hDEAD,
          64'(mk(8'(128 + k), 8'd0, 8'd0, 10'(xs[k]), 9'(ys[k]), k == 7)));

    // random sweep against the reference model
    rst_pulse();
    mx = 0;
    my = 0;
    sb_q.delete();
    sb_on = 1;
    for (int k = 0; k < 600; k++) begin
      i_ready = $urandom_range(0, 3) != 0;
      if (!i_valid || took) begin
        i_valid = $urandom_range(0, 3) != 0;
        i_r = rnd();
        i_g = rnd();
        i_b = rnd();
      end
      @(negedge i_clk);
      took = i_valid && o_ready;
      step();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (6) step();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    sb_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
